// File: rtl/pipeline_stage_monitor.sv
// Debug monitor for the accelerator pipeline. Each stage has sticky
// valid/ready flags, a start-to-done latency measurement and a run counter.
// There is also a one-shot capture of a datapath word. Results are read
// through a registered select port.
module pipeline_stage_monitor #(
   parameter int NUM_STAGES = 4,
   parameter int CNT_W      = 32,
   parameter int CAP_W      = 32,
   parameter int OUT_W      = 32,
   localparam int SEL_W     = $clog2(2*NUM_STAGES+2)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr_i,
   input  logic [NUM_STAGES-1:0]   vld_i,
   input  logic [NUM_STAGES-1:0]   rdy_i,
   input  logic                    cap_trig_i,
   input  logic [CAP_W-1:0]        cap_data_i,
   input  logic [SEL_W-1:0]        sel_i,
   output logic [OUT_W-1:0]        debug_o,
   output logic [2*NUM_STAGES-1:0] flags_o,
   output logic [NUM_STAGES-1:0]   busy_o
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   // Common width that holds every readout source before fitting to OUT_W.
   localparam int W_A  = (OUT_W > CNT_W) ? OUT_W : CNT_W;
   localparam int W_B  = (CAP_W > 2*NUM_STAGES) ? CAP_W : 2*NUM_STAGES;
   localparam int WIDE = (W_A > W_B) ? W_A : W_B;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic [CNT_W-1:0]        lat_next_all  [NUM_STAGES];
   logic [CNT_W-1:0]        runs_next_all [NUM_STAGES];
   logic [2*NUM_STAGES-1:0] flag_hits;
   logic [2*NUM_STAGES-1:0] flags_reg, flags_next;
   logic [CAP_W-1:0]        cap_reg, cap_next;
   logic                    armed_reg, armed_next;
   logic [WIDE-1:0]         wide_sel;
   logic [OUT_W-1:0]        debug_next;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
         state_t           state_reg, state_next;
         logic [CNT_W-1:0] run_cnt_reg, run_cnt_next;
         logic [CNT_W-1:0] lat_reg, lat_next;
         logic [CNT_W-1:0] runs_reg, runs_next;

         // Stage FSM and counter registers; reset aborts any run in flight.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state_reg   <= IDLE;
               run_cnt_reg <= '0;
               lat_reg     <= '0;
               runs_reg    <= '0;
            end else begin
               state_reg   <= state_next;
               run_cnt_reg <= run_cnt_next;
               lat_reg     <= lat_next;
               runs_reg    <= runs_next;
            end
         end

         // Next state: a vld starts a run, and the rdy cycle records the inclusive latency.
         always_comb begin
            state_next   = state_reg;
            run_cnt_next = run_cnt_reg;
            lat_next     = lat_reg;
            runs_next    = runs_reg;
            if (clr_i) begin
               state_next   = IDLE;
               run_cnt_next = '0;
               lat_next     = '0;
               runs_next    = '0;
            end else begin
               case (state_reg)
                  IDLE: begin
                     if (vld_i[gi]) begin
                        if (rdy_i[gi]) begin
                           lat_next  = CNT_W'(1);
                           runs_next = sat_inc(runs_reg);
                        end else begin
                           run_cnt_next = CNT_W'(1);
                           state_next   = RUN;
                        end
                     end
                  end
                  RUN: begin
                     if (rdy_i[gi]) begin
                        lat_next   = sat_inc(run_cnt_reg);
                        runs_next  = sat_inc(runs_reg);
                        state_next = IDLE;
                     end else begin
                        run_cnt_next = sat_inc(run_cnt_reg);
                     end
                  end
                  default: state_next = IDLE;
               endcase
            end
         end

         assign lat_next_all[gi]    = lat_next;
         assign runs_next_all[gi]   = runs_next;
         assign busy_o[gi]          = (state_reg == RUN);
         assign flag_hits[2*gi+1]   = vld_i[gi];
         assign flag_hits[2*gi]     = rdy_i[gi];
      end
   endgenerate

   // Sticky flags and one-shot capture: next-state logic.
   always_comb begin
      flags_next = flags_reg | flag_hits;
      cap_next   = cap_reg;
      armed_next = armed_reg;
      if (clr_i) begin
         flags_next = '0;
         cap_next   = '0;
         armed_next = 1'b1;
      end else if (armed_reg && cap_trig_i) begin
         cap_next   = cap_data_i;
         armed_next = 1'b0;
      end
   end

   // Readout mux selects from the updated values, so debug_o shows state after this edge.
   always_comb begin
      wide_sel = '0;
      if (sel_i == SEL_W'(0)) begin
         wide_sel = WIDE'(flags_next);
      end else if (sel_i == SEL_W'(1)) begin
         wide_sel = WIDE'(cap_next);
      end else begin
         for (int i = 0; i < NUM_STAGES; i++) begin
            if (sel_i == SEL_W'(2 + 2*i)) wide_sel = WIDE'(lat_next_all[i]);
            if (sel_i == SEL_W'(3 + 2*i)) wide_sel = WIDE'(runs_next_all[i]);
         end
      end
      debug_next = clr_i ? '0 : wide_sel[OUT_W-1:0];
   end

   // Global registers: flags, capture and the readout register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_reg <= '0;
         cap_reg   <= '0;
         armed_reg <= 1'b1;
         debug_o   <= '0;
      end else begin
         flags_reg <= flags_next;
         cap_reg   <= cap_next;
         armed_reg <= armed_next;
         debug_o   <= debug_next;
      end
   end

   assign flags_o = flags_reg;

endmodule

// File: tb/tb_pipeline_stage_monitor.sv
// Testbench for pipeline_stage_monitor. Directed scenarios run first, then
// random traffic. All of it is checked against a cycle-index based reference model.
module tb_pipeline_stage_monitor;
   localparam int NS   = 4;
   localparam int CW   = 4;
   localparam int CAPW = 32;
   localparam int OW   = 32;
   localparam int SW   = 4;
   localparam int SAT  = (1 << CW) - 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            clr_i = 1'b0;
   logic            cap_trig_i = 1'b0;
   logic [NS-1:0]   vld_i = '0;
   logic [NS-1:0]   rdy_i = '0;
   logic [CAPW-1:0] cap_data_i = '0;
   logic [SW-1:0]   sel_i = '0;
   logic [OW-1:0]   debug_o;
   logic [2*NS-1:0] flags_o;
   logic [NS-1:0]   busy_o;

   int total = 0;
   int bad   = 0;

   pipeline_stage_monitor #(
      .NUM_STAGES(NS), .CNT_W(CW), .CAP_W(CAPW), .OUT_W(OW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clr_i(clr_i), .vld_i(vld_i), .rdy_i(rdy_i),
      .cap_trig_i(cap_trig_i), .cap_data_i(cap_data_i), .sel_i(sel_i),
      .debug_o(debug_o), .flags_o(flags_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   // Reference model: runs remember their start cycle and latency is the cycle difference.
   int          m_lat   [NS];
   int          m_runs  [NS];
   int          m_start [NS];
   bit          m_run   [NS];
   bit          m_vs    [NS];
   bit          m_rs    [NS];
   logic [31:0] m_cap;
   bit          m_armed;
   int          cyc = 0;
   logic [31:0] m_dbg;

   function automatic int sat(input int v);
      return (v > SAT) ? SAT : v;
   endfunction

   function automatic logic [31:0] m_flags();
      logic [31:0] f = '0;
      for (int i = 0; i < NS; i++) begin
         f[2*i+1] = m_vs[i];
         f[2*i]   = m_rs[i];
      end
      return f;
   endfunction

   function automatic logic [31:0] m_busy();
      logic [31:0] b = '0;
      for (int i = 0; i < NS; i++) b[i] = m_run[i];
      return b;
   endfunction

   function automatic logic [31:0] m_read(input int s);
      if (s == 0) return m_flags();
      if (s == 1) return m_cap;
      if (s >= 2 && s < 2 + 2*NS) begin
         if (s % 2 == 0) return 32'(m_lat[(s-2)/2]);
         return 32'(m_runs[(s-2)/2]);
      end
      return 32'd0;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < NS; i++) begin
         m_lat[i] = 0; m_runs[i] = 0; m_start[i] = 0;
         m_run[i] = 0; m_vs[i] = 0; m_rs[i] = 0;
      end
      m_cap   = '0;
      m_armed = 1'b1;
   endtask

   task automatic m_step();
      if (clr_i) begin
         m_reset();
      end else begin
         for (int i = 0; i < NS; i++) begin
            if (vld_i[i]) m_vs[i] = 1;
            if (rdy_i[i]) m_rs[i] = 1;
            if (!m_run[i]) begin
               if (vld_i[i] && rdy_i[i]) begin
                  m_lat[i]  = 1;
                  m_runs[i] = sat(m_runs[i] + 1);
               end else if (vld_i[i]) begin
                  m_run[i]   = 1;
                  m_start[i] = cyc;
               end
            end else if (rdy_i[i]) begin
               m_lat[i]  = sat(cyc - m_start[i] + 1);
               m_runs[i] = sat(m_runs[i] + 1);
               m_run[i]  = 0;
            end
         end
         if (m_armed && cap_trig_i) begin
            m_cap   = cap_data_i;
            m_armed = 0;
         end
      end
      m_dbg = m_read(int'(sel_i));
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Run one clock with the given inputs, then compare all outputs against the model.
   task automatic tick(input logic [NS-1:0] v, input logic [NS-1:0] r, input logic trig,
                       input logic [31:0] data, input logic [SW-1:0] sel, input logic clr);
      vld_i = v; rdy_i = r; cap_trig_i = trig; cap_data_i = data; sel_i = sel; clr_i = clr;
      @(posedge clk);
      m_step();
      #1;
      chk("debug", debug_o, m_dbg);
      chk("flags", 32'(flags_o), m_flags());
      chk("busy", 32'(busy_o), m_busy());
      $display("cyc=%0d vld=%b rdy=%b trig=%b clr=%b sel=%0d debug=%h flags=%b busy=%b",
               cyc, v, r, trig, clr, sel, debug_o, flags_o, busy_o);
   endtask

   task automatic idle(input int n, input logic [SW-1:0] sel);
      for (int k = 0; k < n; k++) tick('0, '0, 1'b0, 32'd0, sel, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m_reset();
      m_dbg = '0;
      #2;
      chk("rst_debug", debug_o, 32'd0);
      chk("rst_flags", 32'(flags_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      $display("reset applied at t=%0t", $time);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #1;
      do_reset();

      // Every readout after reset is zero, including out-of-range selects.
      for (int s = 0; s < 16; s++) begin
         tick('0, '0, 1'b0, 32'd0, SW'(s), 1'b0);
         chk("rd_zero", debug_o, 32'd0);
      end

      // A single run on stage 0 with latency 10.
      tick(4'b0001, '0, 1'b0, 32'd0, SW'(2), 1'b0);
      for (int k = 0; k < 8; k++) begin
         tick('0, '0, 1'b0, 32'd0, SW'(2), 1'b0);
         chk("busy0_run", 32'(busy_o[0]), 32'd1);
      end
      tick('0, 4'b0001, 1'b0, 32'd0, SW'(2), 1'b0);
      chk("lat0", debug_o, 32'd10);
      chk("busy0_done", 32'(busy_o[0]), 32'd0);
      chk("flags0", 32'(flags_o[1:0]), 32'd3);
      tick('0, '0, 1'b0, 32'd0, SW'(3), 1'b0);
      chk("runs0", debug_o, 32'd1);

      // Same-cycle vld/rdy on stage 2, three times, then a lone rdy.
      for (int k = 0; k < 3; k++) tick(4'b0100, 4'b0100, 1'b0, 32'd0, SW'(6), 1'b0);
      tick('0, '0, 1'b0, 32'd0, SW'(6), 1'b0);
      chk("lat2", debug_o, 32'd1);
      tick('0, '0, 1'b0, 32'd0, SW'(7), 1'b0);
      chk("runs2", debug_o, 32'd3);
      tick('0, 4'b0100, 1'b0, 32'd0, SW'(7), 1'b0);
      chk("runs2_lone_rdy", debug_o, 32'd3);

      // Capture is one-shot until a clear.
      tick('0, '0, 1'b1, 32'h00ABCDEF, SW'(1), 1'b0);
      tick('0, '0, 1'b1, 32'h12345678, SW'(1), 1'b0);
      chk("cap_first", debug_o, 32'h00ABCDEF);
      tick('0, '0, 1'b0, 32'd0, SW'(1), 1'b1);
      chk("clr_debug", debug_o, 32'd0);
      tick('0, '0, 1'b1, 32'h12345678, SW'(1), 1'b0);
      chk("cap_rearm", debug_o, 32'h12345678);

      // Saturation of latency and run count on stage 1.
      tick(4'b0010, '0, 1'b0, 32'd0, SW'(4), 1'b0);
      idle(20, SW'(4));
      tick('0, 4'b0010, 1'b0, 32'd0, SW'(4), 1'b0);
      chk("lat1_sat", debug_o, 32'd15);
      for (int k = 0; k < 20; k++) tick(4'b0010, 4'b0010, 1'b0, 32'd0, SW'(5), 1'b0);
      chk("runs1_sat", debug_o, 32'd15);

      // Reset in the middle of a stage 3 run records nothing.
      tick(4'b1000, '0, 1'b0, 32'd0, SW'(8), 1'b0);
      idle(4, SW'(8));
      do_reset();
      idle(5, SW'(8));
      tick('0, 4'b1000, 1'b0, 32'd0, SW'(8), 1'b0);
      chk("lat3_after_rst", debug_o, 32'd0);
      chk("busy3_after_rst", 32'(busy_o[3]), 32'd0);
      tick('0, '0, 1'b0, 32'd0, SW'(9), 1'b0);
      chk("runs3_after_rst", debug_o, 32'd0);

      // A clear takes priority over a rdy in the same cycle.
      tick(4'b1000, '0, 1'b0, 32'd0, SW'(8), 1'b0);
      idle(3, SW'(8));
      tick('0, 4'b1000, 1'b0, 32'd0, SW'(8), 1'b1);
      chk("clr_rdy_debug", debug_o, 32'd0);
      chk("clr_rdy_busy", 32'(busy_o), 32'd0);
      tick('0, '0, 1'b0, 32'd0, SW'(8), 1'b0);
      chk("clr_rdy_lat3", debug_o, 32'd0);
      tick('0, '0, 1'b0, 32'd0, SW'(9), 1'b0);
      chk("clr_rdy_runs3", debug_o, 32'd0);

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         logic [NS-1:0] v, r;
         for (int i = 0; i < NS; i++) begin
            v[i] = ($urandom_range(0, 3) == 0);
            r[i] = ($urandom_range(0, 4) == 0);
         end
         if ($urandom_range(0, 149) == 0) do_reset();
         tick(v, r, ($urandom_range(0, 15) == 0), $urandom, SW'($urandom_range(0, 15)),
              ($urandom_range(0, 79) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pipeline_stage_monitor.md
Name: pipeline_stage_monitor

Overview:
Parametrised on-chip debug monitor for the GAT accelerator pipeline (SPMM, DMVM, softmax, aggregation, ...).
- Per stage: sticky valid/ready flags, a start-to-done latency measurement and a completed-run counter.
- Global: one-shot trigger capture of an arbitrary datapath word.
- All results are read through a registered select/readout port that drives the board debug outputs.

Parameters:
NUM_STAGES, 4, number of monitored pipeline stages (1..16)
CNT_W, 32, width of per-stage latency and run counters
CAP_W, 32, width of captured datapath word
OUT_W, 32, width of debug readout bus
SEL_W, $clog2(2*NUM_STAGES+2), width of readout select (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clr_i  in  1  synchronous clear of all monitor state
vld_i  in  NUM_STAGES  per-stage start strobe (stage valid)
rdy_i  in  NUM_STAGES  per-stage done strobe (stage ready)
cap_trig_i  in  1  capture trigger
cap_data_i  in  CAP_W  word captured on trigger
sel_i  in  SEL_W  readout select
debug_o  out  OUT_W  registered readout data
flags_o  out  2*NUM_STAGES  sticky flags {vld_seen[i], rdy_seen[i]} for stage i at bits [2i+1:2i]
busy_o  out  NUM_STAGES  stage i FSM in RUN

Behaviour:
Reset is asynchronous, active-low, clock clk.
- All registers clear to 0. FSMs go to IDLE. Capture is re-armed.
- debug_o, flags_o and busy_o are 0.

clr_i is synchronous and has the same effect as reset. It has priority over every event in the same cycle.

Sticky flags:
- vld_seen[i] sets on any cycle with vld_i[i]=1 and holds until reset or clr.
- rdy_seen[i] behaves the same for rdy_i[i].
- flags_o is driven directly from the flag registers, so an input asserted in cycle t is visible on flags_o in cycle t+1.

Per-stage FSM, states IDLE and RUN:
- IDLE, vld_i=1, rdy_i=0: run_cnt <= 1, go to RUN.
- IDLE, vld_i=1, rdy_i=1 in the same cycle: last_lat <= 1, runs <= runs+1, stay in IDLE.
- IDLE, rdy_i=1 alone: ignored (no count change). rdy_seen is still set.
- RUN, rdy_i=0: run_cnt <= run_cnt+1.
- RUN, rdy_i=1: last_lat <= run_cnt+1, runs <= runs+1, go to IDLE.
- Latency is the number of cycles from the vld cycle to the rdy cycle, inclusive.
- vld_i while in RUN is ignored. The run is not restarted.
- run_cnt, last_lat and runs saturate at 2^CNT_W-1 and never wrap.
- busy_o[i] = (state==RUN).

Capture:
- State is an armed bit, set on reset/clr.
- While armed, cap_trig_i=1 sets cap_reg <= cap_data_i and clears armed.
- Later triggers are ignored until clr.

Readout (1-cycle latency): debug_o <= mux(sel_i) on every clock.
- sel 0: flags, zero-extended.
- sel 1: cap_reg.
- sel 2+2i: last_lat[i].
- sel 3+2i: runs[i].
- Any other sel value: 0.
- Values are zero-extended or truncated (LSBs kept) to OUT_W.
- The readout shows register contents after the current cycle's update, i.e. the value visible in cycle t+1 reflects state as of end of cycle t.

Reset mid-run: the FSM aborts to IDLE. No latency is recorded and runs is not incremented.

Test Plan:
1. Reset, then sel=0 -> debug_o=0, flags_o=0. Read sel=1..2*NUM_STAGES+1 -> all 0. sel=2*NUM_STAGES+2 (out of range) -> 0.
2. vld_i[0] pulse at t0, rdy_i[0] pulse at t0+9 -> last_lat[0]=10, runs[0]=1, busy_o[0] high for cycles t0+1..t0+9. flags_o[1:0]=2'b11.
3. vld_i[2] and rdy_i[2] in the same cycle, three times -> sel=6 returns 1, sel=7 returns 3. A lone rdy_i[2] pulse afterwards leaves runs[2]=3.
4. cap_data_i=32'h00ABCDEF with trig, then 32'h12345678 with trig -> sel=1 reads 32'h00ABCDEF. After clr_i and a trig with 32'h12345678 -> reads 32'h12345678.
5. CNT_W=4, vld_i[1] then 20 idle cycles, then rdy_i[1] -> last_lat[1]=15 (saturated). runs[1] also saturates at 15 after 20 runs.
6. vld_i[3] at t0, rst_n low at t0+5, released, rdy_i[3] at t0+12 -> last_lat[3]=0, runs[3]=0, busy_o[3]=0. clr_i in the same cycle as rdy_i -> all counters 0.
